nand_page_prog_seq: RTL and testbench

Sequencer that drives the SPI NAND memory command controller through a complete page-program transaction: WRITE_ENABLE, PROG_LOAD1 (data is taken from the controller's save FIFO), PROG_EXEC, then GET_FEATURE polling of status register C0h until the operation completes. It sits between top-level test/host logic and the memory command controller. It replaces hand-written per-command state machines with a single start/done handshake and a decoded pass/fail result.

---
 rtl/nand_page_prog_seq.sv | 209 ++++++++++++++++++++
 tb/tb_nand_page_prog_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_page_prog_seq.sv
// nand_page_prog_seq
//   Runs one SPI NAND page-program transaction through the memory command
//   controller: WRITE_ENABLE, PROG_LOAD1 (data comes from the controller's
//   save FIFO), PROG_EXEC, then GET_FEATURE polling of status register C0h
//   until OIP clears. The host sees one start/done handshake and a decoded
//   pass/fail status.
//
//   Optional feature macro: PROG_SEQ_TIMEOUT_EN
//     defined   -> polling stops with status 10 once MAX_POLLS polls have
//                  returned OIP=1.
//     undefined -> polling continues while OIP=1; status 10 never occurs.
//
//   Ports
//     i_Clk, i_Rst_L          clock, synchronous active-low reset
//     i_Start                 one-cycle request, sampled only when idle
//     i_Col_Addr/i_Row_Addr   column (PROG_LOAD1) and row (PROG_EXEC)
//     o_Busy/o_Done/o_Status  transaction progress and result
//                             (00 pass, 01 P_FAIL, 10 timeout)
//     o_Last_Feature          last C0h byte captured
//     o_Command/o_CM_DV/o_Addr_Data, i_CM_Ready   controller command port
//     i_RX_Feature_Byte/i_RX_Feature_DV           controller feature return

package nand_page_prog_seq_pkg;
  typedef enum logic [7:0] {
    PROG_LOAD1   = 8'h02,
    WRITE_ENABLE = 8'h06,
    GET_FEATURE  = 8'h0F,
    PROG_EXEC    = 8'h10
  } SPI_Command;
endpackage

module nand_page_prog_seq
  import nand_page_prog_seq_pkg::*;
#(
  parameter int MAX_POLLS = 1000,
  parameter int POLL_GAP  = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Start,
  input  logic [12:0] i_Col_Addr,
  input  logic [23:0] i_Row_Addr,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [1:0]  o_Status,
  output logic [7:0]  o_Last_Feature,
  output SPI_Command  o_Command,
  output logic        o_CM_DV,
  output logic [23:0] o_Addr_Data,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_RX_Feature_Byte,
  input  logic        i_RX_Feature_DV
);

  typedef enum logic [2:0] {
    S_IDLE, S_WEN, S_LOAD, S_EXEC, S_POLL, S_WAIT_FB, S_GAP, S_DONE
  } state_t;

  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_PFAIL   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t      state_q, state_d;
  logic [12:0] col_q, col_d;
  logic [23:0] row_q, row_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  feat_q, feat_d;
  SPI_Command  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic        guard_q, guard_d;

  logic        issue;
  logic [15:0] poll_cnt_inc;
  logic        at_max;
  logic        timeout_hit;

  // Poll count after the byte being captured now; saturates at all-ones.
  assign poll_cnt_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign at_max       = (poll_cnt_inc >= 16'(MAX_POLLS));

`ifdef PROG_SEQ_TIMEOUT_EN
  assign timeout_hit = at_max;
`else
  // Polling never gives up in this build; the limit is masked off.
  assign timeout_hit = 1'b0 & at_max;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    status_d   = status_q;
    feat_d     = feat_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          col_d      = i_Col_Addr;
          row_d      = i_Row_Addr;
          poll_cnt_d = 16'd0;
          status_d   = ST_PASS;
          state_d    = S_WEN;
        end
      end

      // The controller drops Ready one cycle after taking a command, so the
      // cycle right after an issue is never allowed to issue again.
      S_WEN, S_LOAD, S_EXEC, S_POLL: begin
        if (i_CM_Ready && !guard_q) begin
          issue = 1'b1;
          case (state_q)
            S_WEN: begin
              cmd_d   = WRITE_ENABLE;
              addr_d  = 24'd0;
              state_d = S_LOAD;
            end
            S_LOAD: begin
              cmd_d   = PROG_LOAD1;
              addr_d  = {11'd0, col_q};
              state_d = S_EXEC;
            end
            S_EXEC: begin
              cmd_d   = PROG_EXEC;
              addr_d  = row_q;
              state_d = S_POLL;
            end
            default: begin
              cmd_d   = GET_FEATURE;
              addr_d  = {8'd0, 8'hC0, 8'd0};
              state_d = S_WAIT_FB;
            end
          endcase
        end
      end

      S_WAIT_FB: begin
        if (i_RX_Feature_DV) begin
          feat_d     = i_RX_Feature_Byte;
          poll_cnt_d = poll_cnt_inc;
          if (i_RX_Feature_Byte[0]) begin
            if (timeout_hit) begin
              status_d = ST_TIMEOUT;
              state_d  = S_DONE;
            end else begin
              gap_cnt_d = 16'd0;
              state_d   = S_GAP;
            end
          end else begin
            status_d = i_RX_Feature_Byte[3] ? ST_PFAIL : ST_PASS;
            state_d  = S_DONE;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 16'(POLL_GAP - 1)) state_d = S_POLL;
        else                                gap_cnt_d = gap_cnt_q + 16'd1;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    guard_d = issue;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      status_q   <= ST_PASS;
      feat_q     <= '0;
      cmd_q      <= WRITE_ENABLE;
      addr_q     <= '0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      status_q   <= status_d;
      feat_q     <= feat_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      guard_q    <= guard_d;
    end
  end

  // Command/address show the new value in the issue cycle and hold it after.
  assign o_CM_DV        = issue;
  assign o_Command      = cmd_d;
  assign o_Addr_Data    = addr_d;
  assign o_Busy         = (state_q != S_IDLE);
  assign o_Done         = (state_q == S_DONE);
  assign o_Status       = status_q;
  assign o_Last_Feature = feat_q;

endmodule

// File: tb/tb_nand_page_prog_seq.sv
module tb_nand_page_prog_seq;
  import nand_page_prog_seq_pkg::*;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] col;
  logic [23:0] row;
  logic        busy, done;
  logic [1:0]  status;
  logic [7:0]  last_feat;
  SPI_Command  cmd;
  logic        cm_dv;
  logic [23:0] addr;
  logic        ready;
  logic [7:0]  rx_byte;
  logic        rx_dv;

  always #5 clk = ~clk;

  nand_page_prog_seq #(.MAX_POLLS(4), .POLL_GAP(GAP)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start),
    .i_Col_Addr(col), .i_Row_Addr(row),
    .o_Busy(busy), .o_Done(done), .o_Status(status), .o_Last_Feature(last_feat),
    .o_Command(cmd), .o_CM_DV(cm_dv), .o_Addr_Data(addr), .i_CM_Ready(ready),
    .i_RX_Feature_Byte(rx_byte), .i_RX_Feature_DV(rx_dv)
  );

  typedef struct {SPI_Command cmd; logic [23:0] addr;} exp_cmd_t;
  typedef struct {logic [1:0] st; logic [7:0] feat;} exp_done_t;

  exp_cmd_t   exp_q[$];
  exp_done_t  done_q[$];
  logic [7:0] fb_q[$];

  int n_chk = 0, n_err = 0;
  int dv_cnt = 0, done_cnt = 0, fb_sent = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor + feature responder: scores every DV and done pulse against the
  // queues and answers each GET_FEATURE with the next queued byte.
  initial begin
    int cyc = 0, last_dv = -100, last_fb = -100, fb_wait = 0;
    bit fb_oip = 0, prev_done = 0;
    exp_cmd_t e;
    exp_done_t d;
    rx_dv = 0; rx_byte = 0;
    forever begin
      @(negedge clk);
      cyc++;
      rx_dv = 0;
      if (prev_done) chk("busy_after_done", busy, 0);
      prev_done = done;
      if (cm_dv) begin
        dv_cnt++;
        chk("dv_spacing", (cyc - last_dv) >= 2, 1);
        last_dv = cyc;
        if (exp_q.size() == 0) chk("dv_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dv_cmd", cmd, e.cmd);
          chk("dv_addr", addr, e.addr);
        end
        if (cmd == GET_FEATURE) begin
          if (fb_oip) chk("poll_gap", (cyc - last_fb) > GAP, 1);
          fb_wait = 3;
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 1);
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = done_q.pop_front();
          chk("done_status", status, d.st);
          chk("done_last_feat", last_feat, d.feat);
        end
      end
      if (fb_wait > 0) begin
        fb_wait--;
        if (fb_wait == 0 && fb_q.size() > 0) begin
          rx_byte = fb_q.pop_front();
          rx_dv   = 1;
          last_fb = cyc;
          fb_oip  = rx_byte[0];
          fb_sent++;
        end
      end
    end
  end

  task automatic push_cmds(input logic [12:0] c, input logic [23:0] r, input int polls);
    exp_q.push_back('{WRITE_ENABLE, 24'd0});
    exp_q.push_back('{PROG_LOAD1, {11'd0, c}});
    exp_q.push_back('{PROG_EXEC, r});
    for (int i = 0; i < polls; i++) exp_q.push_back('{GET_FEATURE, 24'h00C000});
  endtask

  task automatic start_txn(input logic [12:0] c, input logic [23:0] r);
    @(posedge clk); #1;
    col = c; row = r; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("busy_rise", busy, 1);
    if (ready) chk("first_dv_latency", cm_dv, 1);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 3000) begin @(posedge clk); n++; end
    chk("done_seen", done_cnt != base, 1);
    repeat (3) @(posedge clk);
  endtask

  // One full transaction: feature bytes given, expected status and last byte.
  task automatic run_txn(input logic [12:0] c, input logic [23:0] r,
                         input logic [7:0] bytes[$], input logic [1:0] st);
    int base = done_cnt;
    foreach (bytes[i]) fb_q.push_back(bytes[i]);
    push_cmds(c, r, bytes.size());
    done_q.push_back('{st, bytes[bytes.size()-1]});
    start_txn(c, r);
    wait_done(base);
  endtask

  initial begin
    int base, d0, n;
    rst_n = 0; start = 0; col = 0; row = 0; ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_last_feat", last_feat, 0);
    chk("rst_dv", cm_dv, 0);
    chk("rst_addr", addr, 0);
    chk("rst_cmd", cmd, WRITE_ENABLE);

    run_txn(13'h034, 24'h000100, '{8'h00}, 2'b00);
    run_txn(13'h0F0, 24'h012345, '{8'h01, 8'h01, 8'h00}, 2'b00);
    run_txn(13'h002, 24'h000200, '{8'h08}, 2'b01);
`ifdef PROG_SEQ_TIMEOUT_EN
    run_txn(13'h010, 24'h000300, '{8'h01, 8'h01, 8'h01, 8'h01}, 2'b10);
`else
    run_txn(13'h010, 24'h000300, '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00}, 2'b00);
`endif

    // Ready low after the WRITE_ENABLE issue, with a stray start while busy.
    base = done_cnt;
    fb_q.push_back(8'h00);
    push_cmds(13'h155, 24'h0ABCDE, 1);
    done_q.push_back('{2'b00, 8'h00});
    d0 = dv_cnt;
    start_txn(13'h155, 24'h0ABCDE);
    @(posedge clk); #1 ready = 0;
    repeat (20) @(posedge clk);
    #1 col = 13'h0AA; row = 24'hFFFFFF; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (29) @(posedge clk);
    chk("ready_low_no_dv", dv_cnt - d0, 1);
    #1 ready = 1;
    wait_done(base);
    repeat (60) @(posedge clk);
    chk("single_done", done_cnt - base, 1);

    // Reset while in the poll gap.
    fb_q.push_back(8'h01);
    push_cmds(13'h077, 24'h000777, 1);
    base = fb_sent;
    start_txn(13'h077, 24'h000777);
    n = 0;
    while (fb_sent == base && n < 500) begin @(posedge clk); n++; end
    chk("gap_fb_sent", fb_sent != base, 1);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dv", cm_dv, 0);
    chk("midrst_status", status, 0);
    chk("midrst_last_feat", last_feat, 0);
    chk("midrst_cmd", cmd, WRITE_ENABLE);
    chk("midrst_addr", addr, 0);
    chk("midrst_q_empty", exp_q.size(), 0);
    repeat (GAP + 4) @(posedge clk);
    chk("midrst_no_dv", cm_dv, 0);

    run_txn(13'h1FFF, 24'hFFFFFF, '{8'h01, 8'h00}, 2'b00);
    chk("end_q_empty", exp_q.size() + done_q.size() + fb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
